// File: rtl/bkg_scroll_fetch.sv
// Background scroll/fetch stage: beam position -> background RAM address, RGB re-alignment,
// and frame-synchronous vertical camera scroll via a valid/ready handshake.
module bkg_scroll_fetch (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pix_valid_in,
    input  logic        scroll_valid,
    input  logic [7:0]  scroll_amt,
    output logic        scroll_ready,
    output logic [14:0] read_address,
    input  logic [23:0] ram_data,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        pix_valid_out,
    output logic [7:0]  base_row
);

    localparam int unsigned IMG_H       = 160;
    localparam int unsigned SCALE_SHIFT = 2;
    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned ADDR_W      = 15;
    localparam int unsigned ROW_W       = 8;

    // Scroll state
    logic [ROW_W-1:0]  base_row_q, base_row_d;
    logic [ROW_W-1:0]  pend_amt_q, pend_amt_d;
    logic              pending_q, pending_d;
    logic              ready_q, ready_d;

    // Pixel pipeline state
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              v1_q, v1_d;
    logic              v2_q, v2_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              pv_q, pv_d;

    // Stage 0 intermediates
    logic [ROW_W-1:0]  col;
    logic [8:0]        raw_row;
    logic [8:0]        row_sum;
    logic [ROW_W-1:0]  row;
    logic              in_range;
    logic [ROW_W-1:0]  amt_eff;
    logic              accept;

    // Stage 0 address generation, scroll bookkeeping and next-state for all flops
    always_comb begin
        col      = 8'(DrawX >> SCALE_SHIFT);
        raw_row  = 9'(DrawY >> SCALE_SHIFT);
        row_sum  = raw_row + 9'(base_row_q);
        row      = (row_sum >= 9'(IMG_H)) ? 8'(row_sum - 9'(IMG_H)) : 8'(row_sum);
        in_range = pix_valid_in && (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));

        amt_eff  = (scroll_amt >= 8'(IMG_H)) ? (scroll_amt - 8'(IMG_H)) : scroll_amt;
        accept   = scroll_valid && ready_q;

        base_row_d = base_row_q;
        pend_amt_d = pend_amt_q;
        pending_d  = pending_q;

        // Apply a pending scroll at the frame boundary; wrap mod IMG_H on underflow
        if (frame_start && pending_q) begin
            if (pend_amt_q > base_row_q) begin
                base_row_d = base_row_q + 8'(IMG_H) - pend_amt_q;
            end else begin
                base_row_d = base_row_q - pend_amt_q;
            end
            pending_d = 1'b0;
        end

        // accept only happens with pending clear, so it never collides with the update above
        if (accept) begin
            pend_amt_d = amt_eff;
            pending_d  = 1'b1;
        end
        ready_d = !pending_d;

        // row*160 as (row<<7)+(row<<5)
        addr_d = in_range ? (15'({row, 7'b0}) + 15'({row, 5'b0}) + 15'(col)) : '0;
        v1_d   = in_range;
        v2_d   = v1_q;
        rgb_d  = v2_q ? ram_data : '0;
        pv_d   = v2_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            base_row_q <= '0;
            pend_amt_q <= '0;
            pending_q  <= 1'b0;
            ready_q    <= 1'b0;
            addr_q     <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            rgb_q      <= '0;
            pv_q       <= 1'b0;
        end else begin
            base_row_q <= base_row_d;
            pend_amt_q <= pend_amt_d;
            pending_q  <= pending_d;
            ready_q    <= ready_d;
            addr_q     <= addr_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            rgb_q      <= rgb_d;
            pv_q       <= pv_d;
        end
    end

    assign scroll_ready  = ready_q;
    assign read_address  = addr_q;
    assign Red           = rgb_q[23:16];
    assign Green         = rgb_q[15:8];
    assign Blue          = rgb_q[7:0];
    assign pix_valid_out = pv_q;
    assign base_row      = base_row_q;

endmodule

// File: tb/tb_bkg_scroll_fetch.sv
// Directed bench for bkg_scroll_fetch: address mapping, RGB alignment, scroll handshake.
module tb_bkg_scroll_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        pix_valid_in;
    logic        scroll_valid;
    logic [7:0]  scroll_amt;
    logic        scroll_ready;
    logic [14:0] read_address;
    logic [23:0] ram_data;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic        pix_valid_out;
    logic [7:0]  base_row;

    int checks = 0;
    int errors = 0;

    bkg_scroll_fetch dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .pix_valid_in(pix_valid_in),
        .scroll_valid(scroll_valid), .scroll_amt(scroll_amt), .scroll_ready(scroll_ready),
        .read_address(read_address), .ram_data(ram_data),
        .Red(Red), .Green(Green), .Blue(Blue),
        .pix_valid_out(pix_valid_out), .base_row(base_row)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; frame_start = 1'b0; DrawX = '0; DrawY = '0; pix_valid_in = 1'b0;
        scroll_valid = 1'b0; scroll_amt = '0; ram_data = '0;
        tick(); tick();
        check("rst_ready", 32'(scroll_ready), 0);
        check("rst_base", 32'(base_row), 0);
        check("rst_addr", 32'(read_address), 0);
        check("rst_rgb", {8'd0, Red, Green, Blue}, 0);
        check("rst_pv", 32'(pix_valid_out), 0);
        Reset = 1'b0;
        tick();
        check("ready_after_rst", 32'(scroll_ready), 1);

        // Origin pixel through the full 3-cycle pipeline
        DrawX = 10'd0; DrawY = 10'd0; pix_valid_in = 1'b1;
        tick();
        check("addr_origin", 32'(read_address), 0);
        pix_valid_in = 1'b0;
        tick();
        ram_data = 24'h123456;
        tick();
        check("red", 32'(Red), 32'h12);
        check("green", 32'(Green), 32'h34);
        check("blue", 32'(Blue), 32'h56);
        check("pv_on", 32'(pix_valid_out), 1);
        tick();
        check("pv_off", 32'(pix_valid_out), 0);

        // Corner and small coordinates
        pix_valid_in = 1'b1; DrawX = 10'd639; DrawY = 10'd479;
        tick();
        check("addr_corner", 32'(read_address), 19199);
        DrawX = 10'd4; DrawY = 10'd8;
        tick();
        check("addr_4_8", 32'(read_address), 321);

        // Invalid pixels produce zero address and zero colour despite non-zero RAM data
        pix_valid_in = 1'b0; ram_data = 24'hFFFFFF;
        tick();
        check("addr_invalid", 32'(read_address), 0);
        tick(); tick();
        check("rgb_invalid", {8'd0, Red, Green, Blue}, 0);
        check("pv_invalid", 32'(pix_valid_out), 0);
        pix_valid_in = 1'b1; DrawX = 10'd700; DrawY = 10'd8;
        tick();
        check("addr_x700", 32'(read_address), 0);
        pix_valid_in = 1'b0;
        tick(); tick();
        check("rgb_x700", {8'd0, Red, Green, Blue}, 0);
        check("pv_x700", 32'(pix_valid_out), 0);

        // Scroll by 10 -> base 150
        scroll_valid = 1'b1; scroll_amt = 8'd10;
        check("ready_pre_accept", 32'(scroll_ready), 1);
        tick();
        scroll_valid = 1'b0;
        check("ready_pending", 32'(scroll_ready), 0);
        check("base_before_frame", 32'(base_row), 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("base_150", 32'(base_row), 150);
        check("ready_after_frame", 32'(scroll_ready), 1);
        pix_valid_in = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
        tick();
        check("addr_scrolled", 32'(read_address), 24000);
        DrawY = 10'd40;
        tick();
        check("addr_wrap0", 32'(read_address), 0);
        DrawX = 10'd8; DrawY = 10'd44;
        tick();
        check("addr_wrap1", 32'(read_address), 162);
        pix_valid_in = 1'b0;

        // Large scroll from base 0: 200 -> effective 40 -> base 120
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        check("base_reset", 32'(base_row), 0);
        scroll_valid = 1'b1; scroll_amt = 8'd200;
        tick();
        scroll_valid = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("base_120", 32'(base_row), 120);
        scroll_valid = 1'b1; scroll_amt = 8'd0;
        tick();
        scroll_valid = 1'b0;
        check("ready_zero_pend", 32'(scroll_ready), 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("base_zero_scroll", 32'(base_row), 120);
        check("ready_zero_done", 32'(scroll_ready), 1);

        // Second request while pending is ignored
        scroll_valid = 1'b1; scroll_amt = 8'd20;
        tick();
        scroll_amt = 8'd5;
        check("ready_ignore", 32'(scroll_ready), 0);
        tick();
        scroll_valid = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("base_100", 32'(base_row), 100);

        // Accept coinciding with frame_start waits for the next frame
        scroll_valid = 1'b1; scroll_amt = 8'd30; frame_start = 1'b1;
        tick();
        scroll_valid = 1'b0; frame_start = 1'b0;
        check("base_coincide", 32'(base_row), 100);
        check("ready_coincide", 32'(scroll_ready), 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("base_70", 32'(base_row), 70);
        check("ready_70", 32'(scroll_ready), 1);

        // Reset while pending discards the request
        scroll_valid = 1'b1; scroll_amt = 8'd7;
        tick();
        scroll_valid = 1'b0;
        check("ready_pend7", 32'(scroll_ready), 0);
        Reset = 1'b1;
        tick();
        check("base_rst_pend", 32'(base_row), 0);
        check("ready_in_rst", 32'(scroll_ready), 0);
        Reset = 1'b0;
        tick();
        check("ready_post_rst", 32'(scroll_ready), 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("base_discarded", 32'(base_row), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
